// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS-16 constants, next-bit function and checker state type
package prbs_pkg;

  localparam int PRBS_W = 16;
  localparam int TAP_A  = 15;
  localparam int TAP_B  = 14;
  localparam int TAP_C  = 12;
  localparam int TAP_D  = 3;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // XNOR form: the all-ones history is the lockup state.
  function automatic logic prbs_next(input logic [PRBS_W-1:0] s);
    return ~s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
  endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// rtl/prbs_checker_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over a coincident increment; the count holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS-16 receive checker with BER counters
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_MATCHES = 32,
  parameter int ERR_WIN      = 64,
  parameter int ERR_THRESH   = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] bit_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [7:0]           unlock_cnt
);

  localparam int FW  = $clog2(PRBS_W + 1);
  localparam int MW  = $clog2(LOCK_MATCHES + 1);
  localparam int WBW = $clog2(ERR_WIN + 1);
  localparam int WEW = $clog2(ERR_THRESH + 1);

  localparam logic [FW-1:0]  FILL_FULL  = FW'(PRBS_W);
  localparam logic [MW-1:0]  MATCH_LAST = MW'(LOCK_MATCHES - 1);
  localparam logic [WBW-1:0] WIN_LAST   = WBW'(ERR_WIN - 1);
  localparam logic [WEW-1:0] ERR_LAST   = WEW'(ERR_THRESH - 1);

  chk_state_t        state_q, state_d;
  logic [PRBS_W-1:0] hist_q, hist_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [MW-1:0]     match_q, match_d;
  logic [WBW-1:0]    win_bits_q, win_bits_d;
  logic [WEW-1:0]    win_errs_q, win_errs_d;
  logic              err_pulse_q, err_pulse_d;

  logic pred;
  logic err;
  logic inc_bit;
  logic inc_err;
  logic inc_unlock;

  assign pred = prbs_next(hist_q);
  assign err  = in_bit ^ pred;

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    err_pulse_d = 1'b0;
    inc_bit     = 1'b0;
    inc_err     = 1'b0;
    inc_unlock  = 1'b0;

    if (in_valid) begin
      if (state_q == SEARCH) begin
        hist_d = {hist_q[PRBS_W-2:0], in_bit};
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + FW'(1);
        end else if ((in_bit == pred) && (hist_q != '1)) begin
          if (match_q == MATCH_LAST) begin
            state_d    = LOCKED;
            match_d    = '0;
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            match_d = match_q + MW'(1);
          end
        end else begin
          match_d = '0;
        end
      end else begin
        // Feed back our own prediction so a single flipped bit counts once.
        hist_d      = {hist_q[PRBS_W-2:0], pred};
        inc_bit     = 1'b1;
        inc_err     = err;
        err_pulse_d = err;
        if (err && (win_errs_q == ERR_LAST)) begin
          state_d    = SEARCH;
          fill_d     = '0;
          match_d    = '0;
          inc_unlock = 1'b1;
        end else if (win_bits_q == WIN_LAST) begin
          win_bits_d = '0;
          win_errs_d = '0;
        end else begin
          win_bits_d = win_bits_q + WBW'(1);
          win_errs_d = win_errs_q + WEW'(err);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEARCH;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (inc_bit),
    .q   (bit_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (inc_err),
    .q   (err_cnt)
  );

  sat_counter #(.W(8)) u_unlock_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (inc_unlock),
    .q   (unlock_cnt)
  );

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - scoreboard bench for prbs_checker against a queue-based reference model
module tb_prbs_checker;

  logic        clk;
  logic        rst;
  logic        in_bit;
  logic        in_valid;
  logic        clr_cnt;
  logic        locked;
  logic        err_pulse;
  logic [31:0] bit_cnt;
  logic [31:0] err_cnt;
  logic [7:0]  unlock_cnt;

  prbs_checker dut (
    .clk        (clk),
    .rst        (rst),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .clr_cnt    (clr_cnt),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .bit_cnt    (bit_cnt),
    .err_cnt    (err_cnt),
    .unlock_cnt (unlock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit     locked;
    bit     pulse;
    longint bits;
    longint errs;
    int     unl;
  } exp_t;

  exp_t   sbq[$];
  int     passed = 0;
  int     total  = 0;
  int     pulse_seen = 0;
  logic [15:0] g;

  // Reference model: history as a bit queue, newest at index 0.
  bit     mh[$];
  bit     m_locked;
  int     m_match, m_wb, m_we, m_unl;
  longint m_bits, m_errs;
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  task automatic model_reset();
    mh.delete();
    m_locked = 0;
    m_match = 0; m_wb = 0; m_we = 0; m_unl = 0;
    m_bits = 0; m_errs = 0;
  endtask

  function automatic bit m_pred();
    return !mh[15] ^ mh[14] ^ mh[12] ^ mh[3];
  endfunction

  task automatic model_step(input bit v, input bit b, input bit c);
    exp_t e;
    bit   p, ones, er;
    e.pulse = 0;
    if (v) begin
      if (!m_locked) begin
        if (mh.size() == 16) begin
          p = m_pred();
          ones = 1;
          foreach (mh[i]) if (!mh[i]) ones = 0;
          if (b == p && !ones) m_match++;
          else m_match = 0;
        end
        mh.push_front(b);
        if (mh.size() > 16) void'(mh.pop_back());
        if (m_match == 32) begin
          m_locked = 1; m_match = 0; m_wb = 0; m_we = 0;
        end
      end else begin
        p  = m_pred();
        er = b ^ p;
        mh.push_front(p);
        void'(mh.pop_back());
        if (m_bits < CNT_MAX) m_bits++;
        if (er) begin
          if (m_errs < CNT_MAX) m_errs++;
          e.pulse = 1;
        end
        m_wb++;
        m_we += int'(er);
        if (m_we == 8) begin
          m_locked = 0; mh.delete(); m_match = 0;
          if (m_unl < 255) m_unl++;
        end else if (m_wb == 64) begin
          m_wb = 0; m_we = 0;
        end
      end
    end
    if (c) begin
      m_bits = 0; m_errs = 0;
    end
    e.locked = m_locked;
    e.bits   = m_bits;
    e.errs   = m_errs;
    e.unl    = m_unl;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: the DUT updates outputs every clock, so pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (err_pulse === 1'b1) pulse_seen++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        total++;
        if (locked !== e.locked || err_pulse !== e.pulse || 64'(bit_cnt) != e.bits ||
            64'(err_cnt) != e.errs || 32'(unlock_cnt) != e.unl) begin
          $display("FAIL scoreboard t=%0t: got locked=%0b pulse=%0b bits=%0d errs=%0d unl=%0d expected locked=%0b pulse=%0b bits=%0d errs=%0d unl=%0d",
                   $time, locked, err_pulse, bit_cnt, err_cnt, unlock_cnt,
                   e.locked, e.pulse, e.bits, e.errs, e.unl);
        end else begin
          passed++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic gen_bit(output bit b);
    b = ~g[15] ^ g[14] ^ g[12] ^ g[3];
    g = {g[14:0], b};
  endtask

  task automatic drive(input bit v, input bit b, input bit c);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    clr_cnt  = c;
    model_step(v, b, c);
  endtask

  task automatic send_clean();
    bit b;
    gen_bit(b);
    drive(1'b1, b, 1'b0);
  endtask

  task automatic send_flip(input bit c);
    bit b;
    gen_bit(b);
    drive(1'b1, ~b, c);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst      = 1'b1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit b, v, c;
    int vcount;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    g = 16'h0002;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", longint'(locked), 0);
    chk("rst_err_pulse", longint'(err_pulse), 0);
    chk("rst_bit_cnt", longint'(bit_cnt), 0);
    chk("rst_err_cnt", longint'(err_cnt), 0);
    chk("rst_unlock_cnt", longint'(unlock_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean stream: lock on valid bit 48, then 1000 checked bits.
    repeat (47) send_clean();
    settle();
    chk("t1_not_locked_bit47", longint'(locked), 0);
    send_clean();
    settle();
    chk("t1_locked_bit48", longint'(locked), 1);
    repeat (1000) send_clean();
    settle();
    chk("t1_bit_cnt", longint'(bit_cnt), 1000);
    chk("t1_err_cnt", longint'(err_cnt), 0);

    // Single flipped bit counts exactly once.
    pulse_seen = 0;
    send_flip(1'b0);
    repeat (20) send_clean();
    settle();
    chk("t2_err_cnt", longint'(err_cnt), 1);
    chk("t2_pulses", longint'(pulse_seen), 1);
    chk("t2_locked", longint'(locked), 1);
    chk("t2_unlock_cnt", longint'(unlock_cnt), 0);

    // Eight errors within one window force unlock, then relock after 48 bits.
    do_reset();
    repeat (48) send_clean();
    settle();
    chk("t3_locked_before", longint'(locked), 1);
    for (int i = 0; i < 7; i++) begin
      send_flip(1'b0);
      send_clean();
    end
    send_flip(1'b0);
    settle();
    chk("t3_unlocked", longint'(locked), 0);
    chk("t3_unlock_cnt", longint'(unlock_cnt), 1);
    chk("t3_err_cnt", longint'(err_cnt), 8);
    repeat (47) send_clean();
    settle();
    chk("t3_relock_bit47", longint'(locked), 0);
    send_clean();
    settle();
    chk("t3_relock_bit48", longint'(locked), 1);

    // Constant inputs never lock.
    do_reset();
    repeat (500) drive(1'b1, 1'b1, 1'b0);
    settle();
    chk("t4_const1_locked", longint'(locked), 0);
    do_reset();
    repeat (500) drive(1'b1, 1'b0, 1'b0);
    settle();
    chk("t4_const0_locked", longint'(locked), 0);

    // 50% in_valid duty, 2000 clean valid bits.
    do_reset();
    vcount = 0;
    while (vcount < 2000) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        gen_bit(b);
        vcount++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      drive(v, b, 1'b0);
    end
    settle();
    chk("t5_locked", longint'(locked), 1);
    chk("t5_bit_cnt", longint'(bit_cnt), 1952);
    chk("t5_err_cnt", longint'(err_cnt), 0);

    // clr_cnt coincident with an error wins.
    send_flip(1'b1);
    settle();
    chk("t6_err_cnt_clr", longint'(err_cnt), 0);
    chk("t6_bit_cnt_clr", longint'(bit_cnt), 0);
    chk("t6_locked", longint'(locked), 1);
    repeat (10) send_clean();
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("t6_rst_locked", longint'(locked), 0);
    chk("t6_rst_bit_cnt", longint'(bit_cnt), 0);
    chk("t6_rst_err_cnt", longint'(err_cnt), 0);
    chk("t6_rst_unlock_cnt", longint'(unlock_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random valid, error injection and clears.
    repeat (3000) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 199) == 0);
      if (v) begin
        gen_bit(b);
        if ($urandom_range(0, 15) == 0) b = ~b;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      drive(v, b, c);
    end
    settle();
    repeat (2) @(posedge clk);
    #3;
    chk("scoreboard_drained", longint'(sbq.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
